muldiv_requester: RTL and testbench
===================================

Name: muldiv_requester

Overview:
- EX-stage initiator for the HI/LO multiply/divide engines.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and drives the begin/done handshake of the multiplier controller and the divider engine. Operands go to the engines as magnitudes, and this block applies sign fix-up where the engine does not.
- Stalls the pipeline until results land in HI/LO. Owns the architectural HI/LO registers.

Parameters:
WIDTH, 32, operand width; only 32 supported.
DIVZ_WRITE, 0, divide-by-zero policy: 0 = HI/LO unchanged; 1 = HI<=src_a, LO<=all ones.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
op_valid  in  1  EX holds a HI/LO op
op_code  in  3  md_op_t (MD_NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO)
src_a  in  32  rs value
src_b  in  32  rt value
flush  in  1  discard current/incoming op (exception)
stall_out  out  1  hold EX and earlier stages
hi  out  32  HI register
lo  out  32  LO register
mul_begin  out  1  multiplier request
mul_sign  out  1  negate product (signed, operand signs differ)
mul_a  out  32  |a|
mul_b  out  32  |b|
mul_res  in  64  product, valid only while mul_done
mul_done  in  1  one-cycle completion pulse
div_begin  out  1  divider request
div_a  out  32  |dividend|
div_b  out  32  |divisor|
div_quot  in  32  unsigned quotient, valid only with div_done
div_rem  in  32  unsigned remainder, valid only with div_done
div_done  in  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; hi=lo=0; mul_begin=div_begin=0; stall_out=0; operand regs=0. Reset mid-operation aborts immediately; engines share rst.
- States: IDLE, MUL_WAIT, DIV_WAIT, DRAIN.
- IDLE, op_valid & !flush:
  - MTHI/MTLO: hi/lo <= src_a at the edge; no stall.
  - MULT/MULTU: latch |a|, |b| and sign (a[31]^b[31] for MULT, 0 for MULTU); ->MUL_WAIT; stall_out=1 this cycle.
  - DIV/DIVU with src_b==0: no engine request; apply DIVZ_WRITE; no stall.
  - DIV/DIVU otherwise: latch magnitudes, neg_q=a[31]^b[31], neg_r=a[31] (both 0 for DIVU); ->DIV_WAIT; stall_out=1.
- Magnitude of 0x80000000 is 0x80000000 (unsigned).
- Handshake:
  - *_begin = (state==*_WAIT or DRAIN-for-that-engine) & !*_done.
  - Operands are held stable from the cycle after acceptance until done.
  - begin drops combinationally in the done cycle, so no re-trigger.
- MUL_WAIT, mul_done & !flush: {hi,lo}<=mul_res; stall_out=0 this cycle; ->IDLE.
- DIV_WAIT, div_done & !flush: lo<=neg_q ? -quot : quot; hi<=neg_r ? -rem : rem; stall_out=0; ->IDLE.
- In WAIT states without done: stall_out=1.
- flush:
  - IDLE: op ignored.
  - WAIT state, done not present: ->DRAIN. Keep begin until done, discard result.
  - WAIT state, done in the same cycle: result discarded, ->IDLE.
- DRAIN: stall_out=op_valid (any op); ->IDLE on done; no HI/LO write.
- Latency with 6-cycle multiplier controller: accept cycle 0, begin cycles 1-7, done cycle 8. stall_out high cycles 0-7. HI/LO visible cycle 9.
- Subtraction and negation are two's complement modulo 2^32.

Optional Feature:
- MULDIV_ZERO_FAST_EN defined: MULT/MULTU with src_a==0 or src_b==0 writes hi=lo=0 at the accept edge. No mul_begin, no stall.
- Undefined: such multiplies go through the engine normally.

Decomposition:
- muldiv_pkg: md_op_t enum, md_state_t enum, WIDTH constant.
- One sub-module, muldiv_sign_fix: combinational magnitude (abs) and conditional-negate helper, instantiated for operands and for div results.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF (6-cycle multiplier) -> stall_out high exactly 8 cycles; HI=0xFFFFFFFE, LO=0x00000001.
2. MULT -3 x 7 -> mul_a=3, mul_b=7, mul_sign=1; HI=0xFFFFFFFF, LO=0xFFFFFFEB; mul_begin low in the done cycle.
3. DIV -7 / 2 -> div_a=7, div_b=2; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
4. DIVU 5 / 0 with DIVZ_WRITE=0 -> no div_begin, zero stall, HI/LO unchanged. With DIVZ_WRITE=1 -> HI=5, LO=0xFFFFFFFF.
5. MULT accepted, flush at cycle 3, then MTLO 0x1234 -> DRAIN until mul_done; product discarded; MTLO stalled until DRAIN exits, then LO=0x1234, HI unchanged.
6. rst asserted in MUL_WAIT -> next cycle IDLE, hi=lo=0, mul_begin=0, stall_out=0. A new MULT 2x3 afterwards gives LO=6.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide requester: opcode and FSM state enums.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DRAIN    = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_requester_if.sv
// Engine-side bundle between the requester (master) and the multiplier controller / divider (slave).
interface muldiv_requester_if;
  import muldiv_pkg::*;

  // *_begin is a level request held with stable operands until the engine answers with a
  // one-cycle *_done pulse; results are valid only in that cycle and begin drops in it.
  logic                    mul_begin;
  logic                    mul_sign;
  logic [MD_WIDTH-1:0]     mul_a;
  logic [MD_WIDTH-1:0]     mul_b;
  logic [2*MD_WIDTH-1:0]   mul_res;
  logic                    mul_done;
  logic                    div_begin;
  logic [MD_WIDTH-1:0]     div_a;
  logic [MD_WIDTH-1:0]     div_b;
  logic [MD_WIDTH-1:0]     div_quot;
  logic [MD_WIDTH-1:0]     div_rem;
  logic                    div_done;

  modport master (
    output mul_begin, mul_sign, mul_a, mul_b,
    input  mul_res, mul_done,
    output div_begin, div_a, div_b,
    input  div_quot, div_rem, div_done
  );

  modport slave (
    input  mul_begin, mul_sign, mul_a, mul_b,
    output mul_res, mul_done,
    input  div_begin, div_a, div_b,
    output div_quot, div_rem, div_done
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; with i_neg = sign bit it yields the magnitude.
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [MD_WIDTH-1:0] i_val,
  input  logic                i_neg,
  output logic [MD_WIDTH-1:0] o_val
);

  assign o_val = i_neg ? ('0 - i_val) : i_val;

endmodule

// File: rtl/muldiv_requester.sv
// EX-stage HI/LO requester: owns HI/LO, drives multiplier/divider handshakes, stalls EX.
// Optional MULDIV_ZERO_FAST_EN: multiplies with a zero operand complete at accept.
module muldiv_requester
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIVZ_WRITE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_op_valid,
  input  md_op_t           i_op_code,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_flush,
  output logic             o_stall_out,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output md_state_t        o_state,
  muldiv_requester_if.master eng
);

  md_state_t        r_state, w_next;
  logic [WIDTH-1:0] r_hi, r_lo, r_op_a, r_op_b;
  logic             r_neg_ab, r_neg_a, r_drain_div;

  logic             w_signed, w_mul_fast, w_latch, w_stall;
  logic             w_hi_we, w_lo_we;
  logic [WIDTH-1:0] w_hi_d, w_lo_d, w_abs_a, w_abs_b, w_quot_fix, w_rem_fix;

  assign w_signed = (i_op_code == MD_MULT) || (i_op_code == MD_DIV);

`ifdef MULDIV_ZERO_FAST_EN
  assign w_mul_fast = (i_src_a == '0) || (i_src_b == '0);
`else
  assign w_mul_fast = 1'b0;
`endif

  muldiv_sign_fix u_abs_a (.i_val(i_src_a), .i_neg(w_signed & i_src_a[WIDTH-1]), .o_val(w_abs_a));
  muldiv_sign_fix u_abs_b (.i_val(i_src_b), .i_neg(w_signed & i_src_b[WIDTH-1]), .o_val(w_abs_b));
  muldiv_sign_fix u_fix_q (.i_val(eng.div_quot), .i_neg(r_neg_ab), .o_val(w_quot_fix));
  muldiv_sign_fix u_fix_r (.i_val(eng.div_rem), .i_neg(r_neg_a), .o_val(w_rem_fix));

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_latch = 1'b0;
    w_hi_we = 1'b0;
    w_lo_we = 1'b0;
    w_hi_d  = '0;
    w_lo_d  = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_op_valid && !i_flush) begin
          case (i_op_code)
            MD_MTHI: begin w_hi_we = 1'b1; w_hi_d = i_src_a; end
            MD_MTLO: begin w_lo_we = 1'b1; w_lo_d = i_src_a; end
            MD_MULT, MD_MULTU: begin
              if (w_mul_fast) begin
                w_hi_we = 1'b1;
                w_lo_we = 1'b1;
              end else begin
                w_latch = 1'b1;
                w_stall = 1'b1;
                w_next  = ST_MUL_WAIT;
              end
            end
            MD_DIV, MD_DIVU: begin
              // Divide by zero never reaches the engine; the result policy is a build-time choice.
              if (i_src_b == '0) begin
                if (DIVZ_WRITE != 0) begin
                  w_hi_we = 1'b1;
                  w_hi_d  = i_src_a;
                  w_lo_we = 1'b1;
                  w_lo_d  = '1;
                end
              end else begin
                w_latch = 1'b1;
                w_stall = 1'b1;
                w_next  = ST_DIV_WAIT;
              end
            end
            default: ;
          endcase
        end
      end
      ST_MUL_WAIT: begin
        if (eng.mul_done) begin
          w_next = ST_IDLE;
          if (!i_flush) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
            w_hi_d  = eng.mul_res[2*WIDTH-1:WIDTH];
            w_lo_d  = eng.mul_res[WIDTH-1:0];
          end
        end else begin
          w_stall = 1'b1;
          if (i_flush) w_next = ST_DRAIN;
        end
      end
      ST_DIV_WAIT: begin
        if (eng.div_done) begin
          w_next = ST_IDLE;
          if (!i_flush) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
            w_hi_d  = w_rem_fix;
            w_lo_d  = w_quot_fix;
          end
        end else begin
          w_stall = 1'b1;
          if (i_flush) w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Engine still owes a done pulse; hold any new op until it arrives.
        w_stall = i_op_valid;
        if (r_drain_div ? eng.div_done : eng.mul_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_hi        <= '0;
      r_lo        <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_neg_ab    <= 1'b0;
      r_neg_a     <= 1'b0;
      r_drain_div <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_hi_we) r_hi <= w_hi_d;
      if (w_lo_we) r_lo <= w_lo_d;
      if (w_latch) begin
        r_op_a   <= w_abs_a;
        r_op_b   <= w_abs_b;
        r_neg_ab <= w_signed & (i_src_a[WIDTH-1] ^ i_src_b[WIDTH-1]);
        r_neg_a  <= w_signed & i_src_a[WIDTH-1];
      end
      if (r_state == ST_MUL_WAIT)      r_drain_div <= 1'b0;
      else if (r_state == ST_DIV_WAIT) r_drain_div <= 1'b1;
    end
  end

  assign eng.mul_begin = ((r_state == ST_MUL_WAIT) || (r_state == ST_DRAIN && !r_drain_div)) && !eng.mul_done;
  assign eng.div_begin = ((r_state == ST_DIV_WAIT) || (r_state == ST_DRAIN && r_drain_div)) && !eng.div_done;
  assign eng.mul_sign  = r_neg_ab;
  assign eng.mul_a     = r_op_a;
  assign eng.mul_b     = r_op_b;
  assign eng.div_a     = r_op_a;
  assign eng.div_b     = r_op_b;

  assign o_stall_out = w_stall;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;
  assign o_state     = r_state;

endmodule

// File: tb/tb_muldiv_requester.sv
// Directed bench: dut0 (DIVZ_WRITE=0) with behavioural engines, dut1 (DIVZ_WRITE=1) for divide-by-zero.
`timescale 1ns/1ps
module tb_muldiv_requester;
  import muldiv_pkg::*;

  localparam int MUL_BEGIN_CYC = 7;
  localparam int DIV_BEGIN_CYC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_valid1, flush;
  md_op_t      op_code;
  logic [31:0] src_a, src_b;
  logic        stall0, stall1;
  logic [31:0] hi0, lo0, hi1, lo1;
  md_state_t   state0, state1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] cap_mul_a, cap_mul_b, cap_div_a, cap_div_b;
  logic        cap_mul_sign;

  always #5 clk = ~clk;

  muldiv_requester_if eng0 ();
  muldiv_requester_if eng1 ();

  muldiv_requester #(.WIDTH(32), .DIVZ_WRITE(0)) dut0 (
    .clk(clk), .rst(rst), .i_op_valid(op_valid), .i_op_code(op_code), .i_src_a(src_a),
    .i_src_b(src_b), .i_flush(flush), .o_stall_out(stall0), .o_hi(hi0), .o_lo(lo0),
    .o_state(state0), .eng(eng0.master)
  );

  muldiv_requester #(.WIDTH(32), .DIVZ_WRITE(1)) dut1 (
    .clk(clk), .rst(rst), .i_op_valid(op_valid1), .i_op_code(op_code), .i_src_a(src_a),
    .i_src_b(src_b), .i_flush(flush), .o_stall_out(stall1), .o_hi(hi1), .o_lo(lo1),
    .o_state(state1), .eng(eng1.master)
  );

  // dut1 never gets an engine request in this bench; its engine inputs are idle
  assign eng1.mul_res  = '0;
  assign eng1.mul_done = 1'b0;
  assign eng1.div_quot = '0;
  assign eng1.div_rem  = '0;
  assign eng1.div_done = 1'b0;

  // Behavioural engines: done one cycle after begin has been seen for N cycles
  int mul_cnt, div_cnt;
  always @(posedge clk) begin
    if (rst) begin
      mul_cnt <= 0; eng0.mul_done <= 1'b0;
      div_cnt <= 0; eng0.div_done <= 1'b0;
    end else begin
      eng0.mul_done <= 1'b0;
      eng0.div_done <= 1'b0;
      if (eng0.mul_begin) begin
        if (mul_cnt == MUL_BEGIN_CYC - 1) begin eng0.mul_done <= 1'b1; mul_cnt <= 0; end
        else mul_cnt <= mul_cnt + 1;
      end
      if (eng0.div_begin) begin
        if (div_cnt == DIV_BEGIN_CYC - 1) begin eng0.div_done <= 1'b1; div_cnt <= 0; end
        else div_cnt <= div_cnt + 1;
      end
    end
  end

  logic [63:0] mul_mag;
  assign mul_mag       = {32'd0, eng0.mul_a} * {32'd0, eng0.mul_b};
  assign eng0.mul_res  = eng0.mul_sign ? (64'd0 - mul_mag) : mul_mag;
  assign eng0.div_quot = (eng0.div_b != 0) ? eng0.div_a / eng0.div_b : 32'hFFFFFFFF;
  assign eng0.div_rem  = (eng0.div_b != 0) ? eng0.div_a % eng0.div_b : eng0.div_a;

  // Drive one op for a cycle, then follow it until stall drops; ends one cycle after that.
  task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input bit to_dut1, output int stalls, output int begins,
                        output bit begin_in_done, output bit timed_out);
    bit fin;
    fin = 1'b0; stalls = 0; begins = 0; begin_in_done = 1'b0; timed_out = 1'b0;
    @(negedge clk);
    op_code = op; src_a = a; src_b = b;
    if (to_dut1) op_valid1 = 1'b1; else op_valid = 1'b1;
    #1;
    if (stall0 | stall1) stalls++;
    for (int c = 1; c < 100 && !fin; c++) begin
      @(negedge clk);
      op_valid = 1'b0; op_valid1 = 1'b0; op_code = MD_NONE;
      #1;
      if (c == 1) begin
        cap_mul_a = eng0.mul_a; cap_mul_b = eng0.mul_b; cap_mul_sign = eng0.mul_sign;
        cap_div_a = eng0.div_a; cap_div_b = eng0.div_b;
      end
      if (eng0.mul_begin || eng0.div_begin || eng1.mul_begin || eng1.div_begin) begins++;
      if ((eng0.mul_done && eng0.mul_begin) || (eng0.div_done && eng0.div_begin)) begin_in_done = 1'b1;
      if (stall0 | stall1) stalls++; else fin = 1'b1;
    end
    if (!fin) timed_out = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; op_valid = 1'b0; op_valid1 = 1'b0; flush = 1'b0;
    op_code = MD_NONE; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (state0 !== ST_IDLE) $display("FAIL rst_state0 got=%0d exp=%0d", state0, ST_IDLE); else n_pass++;
    n_checks++; if ({hi0, lo0} !== 64'd0) $display("FAIL rst_hilo0 got=%h exp=0", {hi0, lo0}); else n_pass++;
    n_checks++; if ({hi1, lo1} !== 64'd0) $display("FAIL rst_hilo1 got=%h exp=0", {hi1, lo1}); else n_pass++;
    n_checks++; if ({stall0, stall1, eng0.mul_begin, eng0.div_begin} !== 4'b0)
      $display("FAIL rst_ctrl got=%b exp=0000", {stall0, stall1, eng0.mul_begin, eng0.div_begin}); else n_pass++;
  endtask

  task automatic test_mthi_mtlo;
    int s, b; bit bid, to;
    run_op(MD_MTHI, 32'hCAFE_0001, 32'h0, 1'b0, s, b, bid, to);
    n_checks++; if (s !== 0) $display("FAIL mthi_stall got=%0d exp=0", s); else n_pass++;
    n_checks++; if (hi0 !== 32'hCAFE_0001) $display("FAIL mthi_hi got=%h exp=cafe0001", hi0); else n_pass++;
    run_op(MD_MTLO, 32'hBEEF_0002, 32'h0, 1'b0, s, b, bid, to);
    n_checks++; if (lo0 !== 32'hBEEF_0002) $display("FAIL mtlo_lo got=%h exp=beef0002", lo0); else n_pass++;
    flush = 1'b1;
    run_op(MD_MTHI, 32'h1111_1111, 32'h0, 1'b0, s, b, bid, to);
    flush = 1'b0;
    n_checks++; if (hi0 !== 32'hCAFE_0001) $display("FAIL idle_flush_hi got=%h exp=cafe0001", hi0); else n_pass++;
  endtask

  task automatic test_multu_max;
    int s, b; bit bid, to;
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, s, b, bid, to);
    n_checks++; if (to !== 1'b0) $display("FAIL multu_timeout got=%0d exp=0", to); else n_pass++;
    n_checks++; if (s !== 8) $display("FAIL multu_stall got=%0d exp=8", s); else n_pass++;
    n_checks++; if (b !== 7) $display("FAIL multu_begin_cycles got=%0d exp=7", b); else n_pass++;
    n_checks++; if (cap_mul_sign !== 1'b0) $display("FAIL multu_sign got=%b exp=0", cap_mul_sign); else n_pass++;
    n_checks++; if (hi0 !== 32'hFFFFFFFE) $display("FAIL multu_hi got=%h exp=fffffffe", hi0); else n_pass++;
    n_checks++; if (lo0 !== 32'h00000001) $display("FAIL multu_lo got=%h exp=00000001", lo0); else n_pass++;
  endtask

  task automatic test_mult_signed;
    int s, b; bit bid, to;
    run_op(MD_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, s, b, bid, to);
    n_checks++; if ({cap_mul_a, cap_mul_b} !== {32'd3, 32'd7})
      $display("FAIL mult_operands got=%h/%h exp=3/7", cap_mul_a, cap_mul_b); else n_pass++;
    n_checks++; if (cap_mul_sign !== 1'b1) $display("FAIL mult_sign got=%b exp=1", cap_mul_sign); else n_pass++;
    n_checks++; if (bid !== 1'b0) $display("FAIL mult_begin_in_done got=%b exp=0", bid); else n_pass++;
    n_checks++; if ({hi0, lo0} !== 64'hFFFFFFFF_FFFFFFEB)
      $display("FAIL mult_hilo got=%h exp=ffffffffffffffeb", {hi0, lo0}); else n_pass++;
    run_op(MD_MULT, 32'h80000000, 32'd1, 1'b0, s, b, bid, to);
    n_checks++; if (cap_mul_a !== 32'h80000000) $display("FAIL mult_min_mag got=%h exp=80000000", cap_mul_a); else n_pass++;
    n_checks++; if ({hi0, lo0} !== 64'hFFFFFFFF_80000000)
      $display("FAIL mult_min_hilo got=%h exp=ffffffff80000000", {hi0, lo0}); else n_pass++;
  endtask

  task automatic test_div;
    int s, b; bit bid, to;
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, s, b, bid, to);
    n_checks++; if (to !== 1'b0) $display("FAIL div_timeout got=%0d exp=0", to); else n_pass++;
    n_checks++; if ({cap_div_a, cap_div_b} !== {32'd7, 32'd2})
      $display("FAIL div_operands got=%h/%h exp=7/2", cap_div_a, cap_div_b); else n_pass++;
    n_checks++; if (s !== 5) $display("FAIL div_stall got=%0d exp=5", s); else n_pass++;
    n_checks++; if (lo0 !== 32'hFFFFFFFD) $display("FAIL div_lo got=%h exp=fffffffd", lo0); else n_pass++;
    n_checks++; if (hi0 !== 32'hFFFFFFFF) $display("FAIL div_hi got=%h exp=ffffffff", hi0); else n_pass++;
    run_op(MD_DIVU, 32'd7, 32'd2, 1'b0, s, b, bid, to);
    n_checks++; if ({hi0, lo0} !== {32'd1, 32'd3}) $display("FAIL divu_hilo got=%h exp=0000000100000003", {hi0, lo0}); else n_pass++;
    run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, s, b, bid, to);
    n_checks++; if ({hi0, lo0} !== {32'd1, 32'hFFFFFFFD}) $display("FAIL div_negb_hilo got=%h exp=00000001fffffffd", {hi0, lo0}); else n_pass++;
  endtask

  task automatic test_div_zero;
    int s, b; bit bid, to;
    run_op(MD_MTHI, 32'h0000AAAA, 32'h0, 1'b0, s, b, bid, to);
    run_op(MD_MTLO, 32'h00005555, 32'h0, 1'b0, s, b, bid, to);
    run_op(MD_DIVU, 32'd5, 32'd0, 1'b0, s, b, bid, to);
    n_checks++; if (s !== 0) $display("FAIL divz0_stall got=%0d exp=0", s); else n_pass++;
    n_checks++; if (b !== 0) $display("FAIL divz0_begin got=%0d exp=0", b); else n_pass++;
    n_checks++; if ({hi0, lo0} !== {32'h0000AAAA, 32'h00005555})
      $display("FAIL divz0_hilo got=%h exp=0000aaaa00005555", {hi0, lo0}); else n_pass++;
    run_op(MD_DIVU, 32'd5, 32'd0, 1'b1, s, b, bid, to);
    n_checks++; if (s !== 0) $display("FAIL divz1_stall got=%0d exp=0", s); else n_pass++;
    n_checks++; if ({hi1, lo1} !== {32'd5, 32'hFFFFFFFF})
      $display("FAIL divz1_hilo got=%h exp=00000005ffffffff", {hi1, lo1}); else n_pass++;
  endtask

  task automatic test_mul_zero;
    int s, b; bit bid, to;
    int exp_s;
`ifdef MULDIV_ZERO_FAST_EN
    exp_s = 0;
`else
    exp_s = 8;
`endif
    run_op(MD_MTHI, 32'h99, 32'h0, 1'b0, s, b, bid, to);
    run_op(MD_MTLO, 32'h88, 32'h0, 1'b0, s, b, bid, to);
    run_op(MD_MULTU, 32'd0, 32'd5, 1'b0, s, b, bid, to);
    n_checks++; if (s !== exp_s) $display("FAIL mulzero_stall got=%0d exp=%0d", s, exp_s); else n_pass++;
    n_checks++; if ({hi0, lo0} !== 64'd0) $display("FAIL mulzero_hilo got=%h exp=0", {hi0, lo0}); else n_pass++;
  endtask

  task automatic test_flush_drain;
    int s, b, stalls; bit bid, to, fin;
    run_op(MD_MTHI, 32'h00000BAD, 32'h0, 1'b0, s, b, bid, to);
    run_op(MD_MTLO, 32'h00005555, 32'h0, 1'b0, s, b, bid, to);
    @(negedge clk); op_valid = 1'b1; op_code = MD_MULT; src_a = 32'd5; src_b = 32'd5;
    @(negedge clk); op_valid = 1'b0; op_code = MD_NONE;
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    #1;
    n_checks++; if (state0 !== ST_MUL_WAIT) $display("FAIL flush_wait_state got=%0d exp=%0d", state0, ST_MUL_WAIT); else n_pass++;
    @(negedge clk); flush = 1'b0; op_valid = 1'b1; op_code = MD_MTLO; src_a = 32'h1234;
    #1;
    n_checks++; if (state0 !== ST_DRAIN) $display("FAIL drain_state got=%0d exp=%0d", state0, ST_DRAIN); else n_pass++;
    n_checks++; if (eng0.mul_begin !== 1'b1) $display("FAIL drain_begin got=%b exp=1", eng0.mul_begin); else n_pass++;
    stalls = 0; fin = 1'b0;
    for (int c = 4; c < 100 && !fin; c++) begin
      if (c > 4) begin @(negedge clk); #1; end
      if (stall0) stalls++; else fin = 1'b1;
    end
    n_checks++; if (stalls !== 5) $display("FAIL drain_stall got=%0d exp=5", stalls); else n_pass++;
    n_checks++; if ({hi0, lo0} !== {32'h00000BAD, 32'h00005555})
      $display("FAIL drain_discard got=%h exp=00000bad00005555", {hi0, lo0}); else n_pass++;
    @(negedge clk); op_valid = 1'b0; op_code = MD_NONE;
    #1;
    n_checks++; if ({hi0, lo0} !== {32'h00000BAD, 32'h00001234})
      $display("FAIL drain_mtlo got=%h exp=00000bad00001234", {hi0, lo0}); else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    int s, b; bit bid, to;
    run_op(MD_MTHI, 32'h77, 32'h0, 1'b0, s, b, bid, to);
    @(negedge clk); op_valid = 1'b1; op_code = MD_MULT; src_a = 32'd2; src_b = 32'd3;
    @(negedge clk); op_valid = 1'b0; op_code = MD_NONE;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    n_checks++; if (state0 !== ST_IDLE) $display("FAIL midrst_state got=%0d exp=%0d", state0, ST_IDLE); else n_pass++;
    n_checks++; if ({hi0, lo0} !== 64'd0) $display("FAIL midrst_hilo got=%h exp=0", {hi0, lo0}); else n_pass++;
    n_checks++; if ({eng0.mul_begin, stall0} !== 2'b00)
      $display("FAIL midrst_ctrl got=%b exp=00", {eng0.mul_begin, stall0}); else n_pass++;
    run_op(MD_MULT, 32'd2, 32'd3, 1'b0, s, b, bid, to);
    n_checks++; if (to !== 1'b0) $display("FAIL midrst_timeout got=%0d exp=0", to); else n_pass++;
    n_checks++; if ({hi0, lo0} !== {32'd0, 32'd6}) $display("FAIL midrst_mult got=%h exp=0000000000000006", {hi0, lo0}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_multu_max();
    test_mult_signed();
    test_div();
    test_div_zero();
    test_mul_zero();
    test_flush_drain();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
